// File: rtl/i8088_bus_pkg.sv
// Shared types and constants for the 8088 minimum-mode bus master.
//   bus_state_t : FSM states (IDLE, T1, T2, T3, TW, T4, HOLDST)
//   bus_cmd_t   : captured host command (io, wr, addr, wdata)
//   bus_pins_t  : registered bus pin bundle driven by the top FSM
//   io_mask()   : clears address bits at/above the I/O address width
package i8088_bus_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    T1     = 3'd1,
    T2     = 3'd2,
    T3     = 3'd3,
    TW     = 3'd4,
    T4     = 3'd5,
    HOLDST = 3'd6
  } bus_state_t;

  typedef struct packed {
    logic        io;
    logic        wr;
    logic [19:0] addr;
    logic [7:0]  wdata;
  } bus_cmd_t;

  typedef struct packed {
    logic        ale;
    logic        rd;
    logic        wr;
    logic        den;
    logic        dtr;
    logic        iom;
    logic [11:0] a;
    logic [7:0]  ad_out;
    logic        ad_oe;
    logic        bus_oe;
    logic        hlda;
  } bus_pins_t;

  // Inactive levels of the control strobes.
  localparam logic STROBE_OFF = 1'b1;  // RD, WR, DEN are active low
  localparam logic ALE_OFF    = 1'b0;

  // Pin state while idle (also the reset state).
  localparam bus_pins_t PINS_IDLE = '{
    ale:    ALE_OFF,
    rd:     STROBE_OFF,
    wr:     STROBE_OFF,
    den:    STROBE_OFF,
    dtr:    1'b0,
    iom:    1'b0,
    a:      12'h000,
    ad_out: 8'h00,
    ad_oe:  1'b0,
    bus_oe: 1'b1,
    hlda:   1'b0
  };

  // I/O space is narrower than memory space; bits at or above asize
  // are forced to zero for I/O cycles so decoders never see stale bits.
  function automatic logic [19:0] io_mask(input logic [19:0] addr,
                                          input logic        io,
                                          input int          asize);
    logic [19:0] m;
    m = addr;
    if (io) begin
      for (int i = 0; i < 20; i++) begin
        if (i >= asize) m[i] = 1'b0;
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/bus_wait_timer.sv
// Wait-state counter for the 8088 bus master.
//   CLK, RESET : clock, synchronous active-high reset
//   clr        : clear the count (end of bus cycle)
//   inc        : count one more wait state
//   timeout    : count has reached MAX_WAIT (never set when MAX_WAIT == 0)
module bus_wait_timer #(
  parameter int MAX_WAIT = 16
) (
  input  logic CLK,
  input  logic RESET,
  input  logic clr,
  input  logic inc,
  output logic timeout
);

  localparam int CW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

  logic [CW-1:0] count;

  // Saturating so a disabled timeout cannot wrap back to zero.
  always_ff @(posedge CLK) begin
    if (RESET || clr) begin
      count <= '0;
    end else if (inc && (count != {CW{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

  generate
    if (MAX_WAIT > 0) begin : g_timeout
      assign timeout = (count >= CW'(MAX_WAIT));
    end else begin : g_no_timeout
      assign timeout = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/i8088_bus_master.sv
// 8088 minimum-mode bus cycle initiator.
// Turns single host requests into T1-T2-T3-[Tw]-T4 bus cycles and
// supports HOLD/HLDA bus release.
//   Host side : req, req_ready, req_io, req_wr, req_addr, req_wdata,
//               done, err, rdata
//   Bus side  : READY, HOLD, HLDA, AD_OUT, AD_OE, AD_IN, A, ALE, RD, WR,
//               IOM, DTR, DEN, BUS_OE
// All bus pins are registered and decoded from the next state plus the
// captured command, so nothing on the host side reaches a pin
// combinationally.
module i8088_bus_master
  import i8088_bus_pkg::*;
#(
  parameter int MAX_WAIT = 16,
  parameter int IO_ASIZE = 16
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        req,
  output logic        req_ready,
  input  logic        req_io,
  input  logic        req_wr,
  input  logic [19:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        done,
  output logic        err,
  output logic [7:0]  rdata,
  input  logic        READY,
  input  logic        HOLD,
  output logic        HLDA,
  output logic [7:0]  AD_OUT,
  output logic        AD_OE,
  input  logic [7:0]  AD_IN,
  output logic [11:0] A,
  output logic        ALE,
  output logic        RD,
  output logic        WR,
  output logic        IOM,
  output logic        DTR,
  output logic        DEN,
  output logic        BUS_OE
);

  bus_state_t state, state_nxt;
  bus_cmd_t   cmd, cmd_nxt;
  bus_pins_t  pins;

  logic       timeout;
  logic       wait_inc;
  logic       wait_clr;
  logic       err_nxt;
  logic       cap_rd;
  logic       done_r;
  logic       err_r;
  logic [7:0] rdata_r;

  bus_wait_timer #(
    .MAX_WAIT(MAX_WAIT)
  ) u_wait (
    .CLK     (CLK),
    .RESET   (RESET),
    .clr     (wait_clr),
    .inc     (wait_inc),
    .timeout (timeout)
  );

  // Pin values for a given state and command.
  function automatic bus_pins_t decode(input bus_state_t s, input bus_cmd_t c);
    bus_pins_t p;
    p = PINS_IDLE;
    case (s)
      T1: begin
        p.ale    = 1'b1;
        p.ad_oe  = 1'b1;
        p.ad_out = c.addr[7:0];
        p.a      = c.addr[19:8];
        p.iom    = c.io;
        p.dtr    = c.wr;
      end
      T2, T3, TW: begin
        p.a   = c.addr[19:8];
        p.iom = c.io;
        p.dtr = c.wr;
        p.den = 1'b0;
        if (c.wr) begin
          p.ad_oe  = 1'b1;
          p.ad_out = c.wdata;
          p.wr     = 1'b0;
        end else begin
          p.rd = 1'b0;
        end
      end
      T4: begin
        // Strobes released; a write keeps driving data for hold time.
        p.a   = c.addr[19:8];
        p.iom = c.io;
        p.dtr = c.wr;
        if (c.wr) begin
          p.ad_oe  = 1'b1;
          p.ad_out = c.wdata;
        end
      end
      HOLDST: begin
        p.bus_oe = 1'b0;
        p.hlda   = 1'b1;
      end
      default: p = PINS_IDLE;
    endcase
    return p;
  endfunction

  always_comb begin
    state_nxt = state;
    cmd_nxt   = cmd;
    wait_inc  = 1'b0;
    err_nxt   = 1'b0;
    cap_rd    = 1'b0;
    case (state)
      IDLE: begin
        // HOLD has priority over a simultaneous host request.
        if (HOLD) begin
          state_nxt = HOLDST;
        end else if (req) begin
          cmd_nxt.io    = req_io;
          cmd_nxt.wr    = req_wr;
          cmd_nxt.addr  = io_mask(req_addr, req_io, IO_ASIZE);
          cmd_nxt.wdata = req_wdata;
          state_nxt     = T1;
        end
      end
      T1: state_nxt = T2;
      T2: state_nxt = T3;
      T3, TW: begin
        // READY wins over a timeout reached in the same cycle.
        if (READY) begin
          state_nxt = T4;
          cap_rd    = !cmd.wr;
        end else if (timeout) begin
          state_nxt = T4;
          err_nxt   = 1'b1;
        end else begin
          state_nxt = TW;
          wait_inc  = 1'b1;
        end
      end
      T4:     state_nxt = IDLE;
      HOLDST: if (!HOLD) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign wait_clr = (state == T4);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state   <= IDLE;
      pins    <= PINS_IDLE;
      done_r  <= 1'b0;
      err_r   <= 1'b0;
      rdata_r <= 8'h00;
    end else begin
      state  <= state_nxt;
      pins   <= decode(state_nxt, cmd_nxt);
      done_r <= (state_nxt == T4);
      err_r  <= err_nxt;
      if (cap_rd) rdata_r <= AD_IN;
    end
  end

  // Command is pure data; it is only meaningful once T1 has been entered.
  always_ff @(posedge CLK) begin
    cmd <= cmd_nxt;
  end

  assign req_ready = (state == IDLE) && !HOLD && !RESET;
  assign done      = done_r;
  assign err       = err_r;
  assign rdata     = rdata_r;

  assign ALE    = pins.ale;
  assign RD     = pins.rd;
  assign WR     = pins.wr;
  assign DEN    = pins.den;
  assign DTR    = pins.dtr;
  assign IOM    = pins.iom;
  assign A      = pins.a;
  assign AD_OUT = pins.ad_out;
  assign AD_OE  = pins.ad_oe;
  assign BUS_OE = pins.bus_oe;
  assign HLDA   = pins.hlda;

endmodule

// File: tb/tb_i8088_bus_master.sv
// Directed bench for i8088_bus_master (MAX_WAIT=4, IO_ASIZE=16).
// A table of transactions is replayed with per-phase pin checks; HOLD
// and mid-cycle RESET are covered by hand-written sequences.
module tb_i8088_bus_master;

  logic        CLK;
  logic        RESET;
  logic        req;
  logic        req_ready;
  logic        req_io;
  logic        req_wr;
  logic [19:0] req_addr;
  logic [7:0]  req_wdata;
  logic        done;
  logic        err;
  logic [7:0]  rdata;
  logic        READY;
  logic        HOLD;
  logic        HLDA;
  logic [7:0]  AD_OUT;
  logic        AD_OE;
  logic [7:0]  AD_IN;
  logic [11:0] A;
  logic        ALE;
  logic        RD;
  logic        WR;
  logic        IOM;
  logic        DTR;
  logic        DEN;
  logic        BUS_OE;

  int n_run  = 0;
  int n_fail = 0;

  i8088_bus_master #(
    .MAX_WAIT(4),
    .IO_ASIZE(16)
  ) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .req       (req),
    .req_ready (req_ready),
    .req_io    (req_io),
    .req_wr    (req_wr),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .done      (done),
    .err       (err),
    .rdata     (rdata),
    .READY     (READY),
    .HOLD      (HOLD),
    .HLDA      (HLDA),
    .AD_OUT    (AD_OUT),
    .AD_OE     (AD_OE),
    .AD_IN     (AD_IN),
    .A         (A),
    .ALE       (ALE),
    .RD        (RD),
    .WR        (WR),
    .IOM       (IOM),
    .DTR       (DTR),
    .DEN       (DEN),
    .BUS_OE    (BUS_OE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        io;
    logic        wr;
    logic [19:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  ad_in;
    int          nwait;      // READY=0 samples before READY=1
    logic [11:0] exp_a;
    logic [7:0]  exp_ad1;    // AD_OUT during T1
    logic [7:0]  exp_rdata;  // rdata at done
    logic        exp_err;
    int          exp_lat;    // cycles from accept edge to done
  } txn_t;

  txn_t tbl [6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic run_txn(input txn_t t, input string tag);
    int cyc;
    int w;
    bit got;
    req       = 1'b1;
    req_io    = t.io;
    req_wr    = t.wr;
    req_addr  = t.addr;
    req_wdata = t.wdata;
    AD_IN     = t.ad_in;
    READY     = 1'b1;
    chk($sformatf("%s req_ready", tag), req_ready, 1);
    tick;
    // T1; scramble host inputs to prove the command was captured
    req       = 1'b0;
    req_addr  = 20'h00000;
    req_wdata = 8'h00;
    chk($sformatf("%s T1 ALE", tag), ALE, 1);
    chk($sformatf("%s T1 AD_OE", tag), AD_OE, 1);
    chk($sformatf("%s T1 AD_OUT", tag), AD_OUT, t.exp_ad1);
    chk($sformatf("%s T1 A", tag), A, t.exp_a);
    chk($sformatf("%s T1 IOM", tag), IOM, t.io);
    chk($sformatf("%s T1 DTR", tag), DTR, t.wr);
    chk($sformatf("%s T1 done", tag), done, 0);
    tick;
    // T2
    chk($sformatf("%s T2 ALE", tag), ALE, 0);
    chk($sformatf("%s T2 A", tag), A, t.exp_a);
    chk($sformatf("%s T2 RD", tag), RD, t.wr);
    chk($sformatf("%s T2 WR", tag), WR, !t.wr);
    chk($sformatf("%s T2 DEN", tag), DEN, 0);
    chk($sformatf("%s T2 AD_OE", tag), AD_OE, t.wr);
    if (t.wr) chk($sformatf("%s T2 AD_OUT", tag), AD_OUT, t.wdata);
    tick;
    cyc = 3;
    w   = 0;
    got = 1'b0;
    // T3 and any Tw states
    while (!got && cyc < 20) begin
      READY = (w >= t.nwait);
      chk($sformatf("%s T3/Tw%0d RD", tag, w), RD, t.wr);
      chk($sformatf("%s T3/Tw%0d WR", tag, w), WR, !t.wr);
      chk($sformatf("%s T3/Tw%0d DEN", tag, w), DEN, 0);
      tick;
      cyc++;
      if (done) got = 1'b1;
      else w++;
    end
    READY = 1'b1;
    chk($sformatf("%s latency", tag), cyc, t.exp_lat);
    chk($sformatf("%s T4 done", tag), done, 1);
    chk($sformatf("%s T4 err", tag), err, t.exp_err);
    chk($sformatf("%s T4 rdata", tag), rdata, t.exp_rdata);
    chk($sformatf("%s T4 RD", tag), RD, 1);
    chk($sformatf("%s T4 WR", tag), WR, 1);
    chk($sformatf("%s T4 DEN", tag), DEN, 1);
    chk($sformatf("%s T4 AD_OE", tag), AD_OE, t.wr);
    tick;
    chk($sformatf("%s idle done", tag), done, 0);
    chk($sformatf("%s idle ALE", tag), ALE, 0);
    chk($sformatf("%s idle req_ready", tag), req_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    txn_t fresh;
    //          io    wr    addr       wdata  ad_in  nw  exp_a    ad1    rdata  err   lat
    tbl[0] = '{1'b0, 1'b1, 20'h01234, 8'hA5, 8'h00, 0,  12'h012, 8'h34, 8'h00, 1'b0, 4};
    tbl[1] = '{1'b0, 1'b0, 20'h80010, 8'h00, 8'h3C, 3,  12'h800, 8'h10, 8'h3C, 1'b0, 7};
    tbl[2] = '{1'b1, 1'b1, 20'hAFF05, 8'h77, 8'h00, 0,  12'h0FF, 8'h05, 8'h3C, 1'b0, 4};
    tbl[3] = '{1'b0, 1'b0, 20'h12345, 8'h00, 8'h99, 99, 12'h123, 8'h45, 8'h3C, 1'b1, 8};
    tbl[4] = '{1'b1, 1'b0, 20'h00060, 8'h00, 8'h5A, 1,  12'h000, 8'h60, 8'h5A, 1'b0, 5};
    tbl[5] = '{1'b0, 1'b1, 20'hFFFFF, 8'h00, 8'h00, 4,  12'hFFF, 8'hFF, 8'h5A, 1'b0, 8};

    RESET = 1'b1; req = 1'b0; req_io = 1'b0; req_wr = 1'b0;
    req_addr = 20'h0; req_wdata = 8'h0; READY = 1'b1; HOLD = 1'b0; AD_IN = 8'h0;
    tick;
    tick;
    chk("rst ALE", ALE, 0);
    chk("rst RD", RD, 1);
    chk("rst WR", WR, 1);
    chk("rst DEN", DEN, 1);
    chk("rst DTR", DTR, 0);
    chk("rst IOM", IOM, 0);
    chk("rst A", A, 0);
    chk("rst AD_OUT", AD_OUT, 0);
    chk("rst AD_OE", AD_OE, 0);
    chk("rst BUS_OE", BUS_OE, 1);
    chk("rst HLDA", HLDA, 0);
    chk("rst done", done, 0);
    chk("rst err", err, 0);
    chk("rst rdata", rdata, 0);
    chk("rst req_ready", req_ready, 0);
    RESET = 1'b0;
    #1;
    chk("post-rst req_ready", req_ready, 1);

    for (int i = 0; i < 6; i++) run_txn(tbl[i], $sformatf("tbl%0d", i));

    // HOLD together with a request: HOLD wins, request starts after release
    HOLD = 1'b1; req = 1'b1; req_io = 1'b0; req_wr = 1'b0;
    req_addr = 20'h00100; AD_IN = 8'h11; READY = 1'b1;
    #1;
    chk("hold req_ready", req_ready, 0);
    tick;
    chk("hold HLDA", HLDA, 1);
    chk("hold BUS_OE", BUS_OE, 0);
    chk("hold AD_OE", AD_OE, 0);
    chk("hold req_ready in HOLDST", req_ready, 0);
    chk("hold ALE", ALE, 0);
    tick;
    chk("hold HLDA stays", HLDA, 1);
    HOLD = 1'b0;
    tick;
    chk("release HLDA", HLDA, 0);
    chk("release BUS_OE", BUS_OE, 1);
    chk("release ALE", ALE, 0);
    chk("release req_ready", req_ready, 1);
    tick;
    chk("hold-txn T1 ALE", ALE, 1);
    chk("hold-txn T1 A", A, 12'h001);
    req = 1'b0;
    HOLD = 1'b1;  // raised mid-cycle; must be deferred until IDLE
    tick;
    chk("mid HOLD T2 HLDA", HLDA, 0);
    chk("mid HOLD T2 RD", RD, 0);
    chk("mid HOLD T2 BUS_OE", BUS_OE, 1);
    tick;
    chk("mid HOLD T3 HLDA", HLDA, 0);
    tick;
    chk("mid HOLD T4 done", done, 1);
    chk("mid HOLD T4 rdata", rdata, 8'h11);
    chk("mid HOLD T4 HLDA", HLDA, 0);
    tick;
    chk("mid HOLD idle HLDA", HLDA, 0);
    chk("mid HOLD idle req_ready", req_ready, 0);
    tick;
    chk("mid HOLD HOLDST HLDA", HLDA, 1);
    HOLD = 1'b0;
    tick;
    chk("mid HOLD release HLDA", HLDA, 0);

    // RESET pulse during T3 of a write aborts without done
    req = 1'b1; req_io = 1'b0; req_wr = 1'b1; req_addr = 20'h00200; req_wdata = 8'hC3;
    tick;
    req = 1'b0;
    chk("abort T1 ALE", ALE, 1);
    tick;
    tick;
    chk("abort T3 WR", WR, 0);
    RESET = 1'b1;
    tick;
    RESET = 1'b0;
    chk("abort WR", WR, 1);
    chk("abort DEN", DEN, 1);
    chk("abort AD_OE", AD_OE, 0);
    chk("abort ALE", ALE, 0);
    chk("abort done", done, 0);
    chk("abort rdata", rdata, 0);
    tick;
    chk("abort no done", done, 0);
    chk("abort idle ALE", ALE, 0);
    chk("abort req_ready", req_ready, 1);

    fresh = '{1'b0, 1'b0, 20'h00300, 8'h00, 8'h42, 2, 12'h003, 8'h00, 8'h42, 1'b0, 6};
    run_txn(fresh, "post-abort");

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
